// File: rtl/bsg_mul_pipelined_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_mul_pipelined_arb
//  Description : Round-robin front end that shares one external pipelined
//                multiplier (bsg_mul_pipelined) among num_req_p requesters.
//                A shadow valid/tag pipeline matching the multiplier latency
//                tags each product with its owner and presents it on a
//                valid/ready port. Backpressure freezes the whole pipe
//                (including empty stages) by dropping the multiplier enable.
//  Options     : define BSG_MUL_PIPELINED_ARB_STATS_EN to add the
//                issue_count_o / stall_count_o statistics ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_mul_pipelined_arb #(
    parameter int  width_p     = 128,
    parameter int  num_req_p   = 4,
    parameter int  latency_p   = 3,
    localparam int tag_width_p = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clock_i,
    input  logic                           reset_i,

    // requester side
    input  logic [num_req_p-1:0]           v_i,
    input  logic [num_req_p*width_p-1:0]   x_i,
    input  logic [num_req_p*width_p-1:0]   y_i,
    input  logic [num_req_p-1:0]           signed_i,
    output logic [num_req_p-1:0]           ready_o,

    // multiplier side
    output logic                           mul_en_o,
    output logic [width_p-1:0]             mul_x_o,
    output logic [width_p-1:0]             mul_y_o,
    output logic                           mul_signed_o,
    input  logic [2*width_p-1:0]           mul_z_i,

    // result side
    output logic                           v_o,
    output logic [2*width_p-1:0]           z_o,
    output logic [tag_width_p-1:0]         tag_o,
    input  logic                           ready_i
`ifdef BSG_MUL_PIPELINED_ARB_STATS_EN
    ,
    output logic [31:0]                    issue_count_o,
    output logic [31:0]                    stall_count_o
`endif
);

    // After reset the pointer sits on the last requester so index 0 is
    // scanned first.
    localparam logic [tag_width_p-1:0] c_last_init = tag_width_p'(num_req_p - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                   r_v   [latency_p];
    logic [tag_width_p-1:0] r_tag [latency_p];
    logic [tag_width_p-1:0] r_last;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                   w_advance;
    logic                   w_found;
    logic                   w_issue;
    logic [tag_width_p-1:0] w_grant;

    // Requester index visited 'offset' positions after 'base', wrapping.
    function automatic logic [tag_width_p-1:0] f_rr_index(
        input logic [tag_width_p-1:0] base,
        input int                     offset
    );
        return tag_width_p'((int'(base) + offset) % num_req_p);
    endfunction

    // The result port is forced quiet while reset is held so that the pipe
    // keeps flushing (advance stays high) during reset.
    assign v_o       = r_v[latency_p-1] & ~reset_i;
    assign tag_o     = r_tag[latency_p-1];
    assign z_o       = mul_z_i;

    // The whole pipe moves only when the head is empty or being consumed.
    assign w_advance = ~v_o | ready_i;
    assign mul_en_o  = w_advance;

    assign w_issue   = (|v_i) & w_advance & ~reset_i;

    // Round-robin search: first valid requester after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            if (!w_found && v_i[f_rr_index(r_last, k)]) begin
                w_found = 1'b1;
                w_grant = f_rr_index(r_last, k);
            end
        end
    end

    // Only the granted requester sees ready, and only when the pipe moves.
    always_comb begin
        ready_o = '0;
        if (w_found && w_advance && !reset_i) begin
            ready_o[w_grant] = 1'b1;
        end
    end

    // Steer the granted requester's operands to the multiplier; zero when idle.
    always_comb begin
        mul_x_o      = '0;
        mul_y_o      = '0;
        mul_signed_o = 1'b0;
        if (w_found) begin
            mul_x_o      = x_i[int'(w_grant)*width_p +: width_p];
            mul_y_o      = y_i[int'(w_grant)*width_p +: width_p];
            mul_signed_o = signed_i[w_grant];
        end
    end

    // ------------------------------------------------------------------------
    // Shadow pipeline: mirrors the multiplier's en-gated stages one-for-one so
    // the head valid/tag line up with mul_z_i. Empty stages shift like full
    // ones; a stall freezes everything.
    // ------------------------------------------------------------------------
    // Shift valid/tag and update the round-robin pointer on advance.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int s = 0; s < latency_p; s++) begin
                r_v[s]   <= 1'b0;
                r_tag[s] <= '0;
            end
            r_last <= c_last_init;
        end else if (w_advance) begin
            r_v[0]   <= w_issue;
            r_tag[0] <= w_grant;
            for (int s = 1; s < latency_p; s++) begin
                r_v[s]   <= r_v[s-1];
                r_tag[s] <= r_tag[s-1];
            end
            if (w_issue) begin
                r_last <= w_grant;
            end
        end
    end

`ifdef BSG_MUL_PIPELINED_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics: free-running 32-bit counters that wrap naturally.
    // ------------------------------------------------------------------------
    logic [31:0] r_issue_count;
    logic [31:0] r_stall_count;

    // Count issued operations and cycles where a valid result is held back.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_issue) begin
                r_issue_count <= r_issue_count + 32'd1;
            end
            if (v_o && !ready_i) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign issue_count_o = r_issue_count;
    assign stall_count_o = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_mul_pipelined_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_mul_pipelined_arb
//  Description : Scoreboard bench for bsg_mul_pipelined_arb. Contains an
//                en-gated multiplier model feeding mul_z_i, a queue-based
//                reference of in-flight operations, and a separate monitor
//                that pops and compares every consumed result.
//                Honours BSG_MUL_PIPELINED_ARB_STATS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_mul_pipelined_arb;

    localparam int W  = 128;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N-1:0]      v_i;
    logic [N*W-1:0]    x_i;
    logic [N*W-1:0]    y_i;
    logic [N-1:0]      signed_i;
    logic [N-1:0]      ready_o;
    logic              mul_en_o;
    logic [W-1:0]      mul_x_o;
    logic [W-1:0]      mul_y_o;
    logic              mul_signed_o;
    logic [2*W-1:0]    mul_z_i;
    logic              v_o;
    logic [2*W-1:0]    z_o;
    logic [TW-1:0]     tag_o;
    logic              ready_i;
`ifdef BSG_MUL_PIPELINED_ARB_STATS_EN
    logic [31:0]       issue_count_o;
    logic [31:0]       stall_count_o;
`endif

    bsg_mul_pipelined_arb #(
        .width_p   (W),
        .num_req_p (N),
        .latency_p (L)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .signed_i     (signed_i),
        .ready_o      (ready_o),
        .mul_en_o     (mul_en_o),
        .mul_x_o      (mul_x_o),
        .mul_y_o      (mul_y_o),
        .mul_signed_o (mul_signed_o),
        .mul_z_i      (mul_z_i),
        .v_o          (v_o),
        .z_o          (z_o),
        .tag_o        (tag_o),
        .ready_i      (ready_i)
`ifdef BSG_MUL_PIPELINED_ARB_STATS_EN
        ,
        .issue_count_o(issue_count_o),
        .stall_count_o(stall_count_o)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference arithmetic: full-width product modulo 2^(2W)
    // ------------------------------------------------------------------------
    function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic         s);
        logic [2*W-1:0] ae;
        logic [2*W-1:0] be;
        ae = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        be = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ae * be;
    endfunction

    // Behavioural multiplier: L en-gated stages.
    logic [2*W-1:0] mstage [L];
    always @(posedge clk) begin
        if (mul_en_o) begin
            mstage[0] <= mul_ref(mul_x_o, mul_y_o, mul_signed_o);
            for (int s = 1; s < L; s++) mstage[s] <= mstage[s-1];
        end
    end
    assign mul_z_i = mstage[L-1];

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    typedef struct {
        logic [2*W-1:0] z;
        int             tag;
        int             rem;   // advancing cycles still needed to reach head
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           last_g   = N - 1;
    int           m_issues = 0;
    int           m_stalls = 0;

    logic [W-1:0] req_x [N];
    logic [W-1:0] req_y [N];
    logic [N-1:0] req_s;
    logic [N-1:0] req_v;
    logic [N-1:0] acc;

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic s);
        req_x[i] = x;
        req_y[i] = y;
        req_s[i] = s;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = '1;
            2:       r = {1'b1, {(W-1){1'b0}}};
            default: r = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return r;
    endfunction

    // One clock cycle: drive inputs, then check control outputs against the
    // reference and record any accepted operation.
    task automatic step(input logic rst, input logic rdy);
        logic         exp_vo;
        logic         exp_adv;
        logic [N-1:0] exp_rdy;
        int           g;
        int           idx;
        @(negedge clk);
        reset_i  = rst;
        ready_i  = rdy;
        v_i      = req_v;
        signed_i = req_s;
        for (int i = 0; i < N; i++) begin
            x_i[i*W +: W] = req_x[i];
            y_i[i*W +: W] = req_y[i];
        end
        #2;
        exp_vo  = !rst && (sb.size() > 0) && (sb[0].rem == 0);
        exp_adv = !exp_vo || rdy;
        check("v_o", v_o, exp_vo);
        check("mul_en_o", mul_en_o, exp_adv);
        g = -1;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                idx = (last_g + k) % N;
                if (g < 0 && req_v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0 && exp_adv) exp_rdy[g] = 1'b1;
        check("ready_o", ready_o, exp_rdy);
        acc = exp_rdy;
        if (rst) begin
            sb.delete();
            last_g   = N - 1;
            m_issues = 0;
            m_stalls = 0;
        end else begin
            if (exp_vo && !rdy) m_stalls++;
            if (exp_adv) begin
                foreach (sb[j]) if (sb[j].rem > 0) sb[j].rem--;
            end
            if (exp_rdy != '0) begin
                check("mul_x_o", mul_x_o, req_x[g]);
                check("mul_y_o", mul_y_o, req_y[g]);
                check("mul_signed_o", mul_signed_o, req_s[g]);
                sb.push_back('{z: mul_ref(req_x[g], req_y[g], req_s[g]),
                               tag: g, rem: L - 1});
                last_g = g;
                m_issues++;
            end
        end
    endtask

    // Monitor: compare every result the consumer takes against the queue head.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (v_o === 1'b1 && ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got tag %0d z %0h expected no result",
                         tag_o, z_o);
            end else begin
                e = sb.pop_front();
                check("z_o", z_o, e.z);
                check("tag_o", tag_o, e.tag);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int cnt;
        reset_i  = 1'b1;
        ready_i  = 1'b1;
        v_i      = '0;
        x_i      = '0;
        y_i      = '0;
        signed_i = '0;
        req_v    = '0;
        req_s    = '0;
        acc      = '0;
        for (int i = 0; i < N; i++) set_req(i, '0, '0, 1'b0);

        repeat (3) step(1'b1, 1'b1);

        // single unsigned op from requester 0
        set_req(0, 128'd3, 128'd5, 1'b0);
        req_v = 4'b0001;
        step(1'b0, 1'b1);
        req_v = '0;
        repeat (L + 2) step(1'b0, 1'b1);

        // signed then unsigned multiply of -2 * 7 from requester 2
        set_req(2, {{(W-1){1'b1}}, 1'b0}, 128'd7, 1'b1);
        req_v = 4'b0100;
        step(1'b0, 1'b1);
        req_s[2] = 1'b0;
        step(1'b0, 1'b1);
        req_v = '0;
        repeat (L + 2) step(1'b0, 1'b1);

        // round-robin fairness from a fresh reset
        step(1'b1, 1'b1);
        for (int i = 0; i < N; i++) set_req(i, 128'(100 + i), 128'(200 + i), i[0]);
        req_v = 4'b1111;
        repeat (8) step(1'b0, 1'b1);
        req_v = '0;
        repeat (L + 2) step(1'b0, 1'b1);

        // backpressure: six ops with a five-cycle consumer stall mid-stream
        cnt = 0;
        set_req(0, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        req_v = 4'b0001;
        for (int c = 0; c < 24; c++) begin
            step(1'b0, !(c >= 4 && c < 9));
            if (acc[0]) begin
                cnt++;
                if (cnt == 6) req_v = '0;
                else set_req(0, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            end
        end

        // idle requesters are skipped
        req_v = 4'b1010;
        repeat (6) step(1'b0, 1'b1);
        req_v = '0;
        repeat (L + 2) step(1'b0, 1'b1);

        // reset with operations in flight, then grant restarts at 0
        req_v = 4'b1111;
        repeat (3) step(1'b0, 1'b1);
        req_v = '0;
        step(1'b1, 1'b1);
        repeat (L + 2) step(1'b0, 1'b1);
        req_v = 4'b1111;
        step(1'b0, 1'b1);
        req_v = '0;
        repeat (L + 2) step(1'b0, 1'b1);

        // randomized traffic; un-accepted requests stay stable
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_v[i] && !acc[i])) begin
                    req_v[i] = ($urandom_range(0, 99) < 60);
                    set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
                end
            end
            step(1'b0, $urandom_range(0, 3) != 0);
        end

        // drain with a bounded cycle budget
        req_v = '0;
        for (int c = 0; c < 100 && sb.size() > 0; c++) step(1'b0, 1'b1);
        check("scoreboard_drained", 256'(sb.size()), 256'd0);

`ifdef BSG_MUL_PIPELINED_ARB_STATS_EN
        check("issue_count_o", issue_count_o, 32'(m_issues));
        check("stall_count_o", stall_count_o, 32'(m_stalls));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
